// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg -- shared constants for the EX stage of the 5-stage MIPS pipeline.
//   Bus widths, stall-vector encoding, SPECIAL funct codes for the HI/LO
//   instructions, store opcodes, divider FSM state type and a sign-extend helper.
//   Build option: EX_MULDIV_EN (see ex_stage.sv).
package ex_stage_pkg;

  localparam int unsigned ID_TO_EX_WD  = 159;
  localparam int unsigned EX_TO_MEM_WD = 76;
  localparam int unsigned EX_TO_RF_WD  = 38;
  localparam int unsigned StallBus     = 6;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1a;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1b;

  localparam logic [5:0] OP_SB = 6'h28;
  localparam logic [5:0] OP_SH = 6'h29;
  localparam logic [5:0] OP_SW = 6'h2b;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_DONE
  } div_state_e;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/ex_stage_div_iter.sv
// div_iter -- 32-step restoring divider used by ex_stage for div/divu.
//   Only built when EX_MULDIV_EN is defined.
// Ports:
//   clk, rst        clock, synchronous active-high reset (discards a partial divide)
//   start           a div/divu is currently in EX
//   is_signed       1 = div, 0 = divu
//   advance         the ID/EX register loads on this edge (stall[2] = NoStop)
//   dividend/divisor operands (rs, rt)
//   busy            stall request: decision cycle plus the 32 step cycles
//   done            result valid; held until advance
//   quotient/remainder sign-corrected result
`ifdef EX_MULDIV_EN
module div_iter
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic        advance,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  div_state_e  state, state_nxt;
  logic [4:0]  count;
  logic [31:0] rem, quo, dvs;
  logic        neg_q, neg_r;
  logic [31:0] dvd_abs, dvs_abs;
  logic [32:0] shifted, trial;
  logic        fits;
  logic        unused_borrow;

  assign dvd_abs = (is_signed && dividend[31]) ? -dividend : dividend;
  assign dvs_abs = (is_signed && divisor[31])  ? -divisor  : divisor;

  // Divide-by-zero needs no special case: every trial fits, so the quotient
  // fills with ones and the dividend bits shift straight into the remainder.
  assign shifted       = {rem, quo[31]};
  assign trial         = shifted - {1'b0, dvs};
  assign fits          = shifted >= {1'b0, dvs};
  assign unused_borrow = trial[32];

  always_ff @(posedge clk) begin
    if (rst) state <= DIV_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DIV_IDLE: if (start)          state_nxt = DIV_BUSY;
      DIV_BUSY: if (count == 5'd31) state_nxt = DIV_DONE;
      DIV_DONE: if (advance)        state_nxt = DIV_IDLE;
      default:                      state_nxt = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == DIV_IDLE && start) begin
      count <= '0;
      rem   <= '0;
      quo   <= dvd_abs;
      dvs   <= dvs_abs;
      neg_q <= is_signed & (dividend[31] ^ divisor[31]);
      neg_r <= is_signed & dividend[31];
    end else if (state == DIV_BUSY) begin
      rem   <= fits ? trial[31:0] : shifted[31:0];
      quo   <= {quo[30:0], fits};
      count <= count + 5'd1;
    end
  end

  always_comb begin
    busy      = (state == DIV_IDLE && start) || state == DIV_BUSY;
    done      = state == DIV_DONE;
    quotient  = neg_q ? -quo : quo;
    remainder = neg_r ? -rem : rem;
  end

endmodule
`endif

// File: rtl/ex_stage.sv
// ex_stage -- execute stage of the 5-stage MIPS pipeline (between ID and MEM).
//   Registers the ID->EX bus, selects operands, runs the one-hot ALU, drives
//   the data-SRAM request, and forwards its result to ID.
//   Build option EX_MULDIV_EN: adds HI/LO, the one-cycle multiplier, the
//   iterative divider (div_iter) and its stall request. Without it the stage
//   is a pure 1-cycle ALU/AGU, mfhi/mflo return 0 and stallreq_for_ex is 0.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   stall             CTRL stall vector (bit 2 ID/EX, bit 3 EX/MEM)
//   id_to_ex_bus      decoded instruction from ID
//   ex_to_mem_bus     {pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result}
//   ex_to_rf_bus      {rf_we, rf_waddr, ex_result} forwarding path to ID
//   ex_is_load        load in EX (load-use hazard detection)
//   stallreq_for_ex   divide in progress
//   data_sram_*       data-SRAM enable, byte write enables, address, store data
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [StallBus-1:0]     stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [EX_TO_RF_WD-1:0]  ex_to_rf_bus,
  output logic                    ex_is_load,
  output logic                    stallreq_for_ex,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata
);

  logic [ID_TO_EX_WD-1:0] bus_r;

  always_ff @(posedge clk) begin
    if (rst)                                       bus_r <= '0;
    else if (stall[2] == Stop && stall[3] == NoStop) bus_r <= '0;
    else if (stall[2] == NoStop)                   bus_r <= id_to_ex_bus;
  end

  logic [31:0] pc, inst, rs_data, rt_data;
  logic [11:0] alu_op;
  logic [2:0]  sel_src1;
  logic [3:0]  sel_src2;
  logic        ram_en, rf_we, sel_rf_res;
  logic [3:0]  ram_wen;
  logic [4:0]  rf_waddr;

  assign {pc, inst, alu_op, sel_src1, sel_src2, ram_en, ram_wen,
          rf_we, rf_waddr, sel_rf_res, rs_data, rt_data} = bus_r;

  logic [5:0]  opcode;
  logic [31:0] imm_sext, imm_zext;
  assign opcode   = inst[31:26];
  assign imm_sext = sext16(inst[15:0]);
  assign imm_zext = {16'b0, inst[15:0]};

  logic [31:0] src1, src2;
  assign src1 = ({32{sel_src1[0]}} & rs_data)
              | ({32{sel_src1[1]}} & pc)
              | ({32{sel_src1[2]}} & {27'b0, inst[10:6]});
  assign src2 = ({32{sel_src2[0]}} & rt_data)
              | ({32{sel_src2[1]}} & imm_sext)
              | ({32{sel_src2[2]}} & 32'd8)
              | ({32{sel_src2[3]}} & imm_zext);

  logic [31:0] sra_res, alu_res;
  assign sra_res = $unsigned($signed(src2) >>> src1[4:0]);
  assign alu_res = ({32{alu_op[11]}} & (src1 + src2))
                 | ({32{alu_op[10]}} & (src1 - src2))
                 | ({32{alu_op[9]}}  & {31'b0, $signed(src1) < $signed(src2)})
                 | ({32{alu_op[8]}}  & {31'b0, src1 < src2})
                 | ({32{alu_op[7]}}  & (src1 & src2))
                 | ({32{alu_op[6]}}  & ~(src1 | src2))
                 | ({32{alu_op[5]}}  & (src1 | src2))
                 | ({32{alu_op[4]}}  & (src1 ^ src2))
                 | ({32{alu_op[3]}}  & (src2 << src1[4:0]))
                 | ({32{alu_op[2]}}  & (src2 >> src1[4:0]))
                 | ({32{alu_op[1]}}  & sra_res)
                 | ({32{alu_op[0]}}  & {src2[15:0], 16'b0});

  logic [31:0] addr, wdata;
  logic [3:0]  lanes;
  assign addr = rs_data + imm_sext;

  always_comb begin
    lanes = '0;
    wdata = rt_data;
    case (opcode)
      OP_SW: lanes = 4'b1111;
      OP_SH: begin
        lanes = 4'b0011 << {addr[1], 1'b0};
        wdata = {2{rt_data[15:0]}};
      end
      OP_SB: begin
        lanes = 4'b0001 << addr[1:0];
        wdata = {4{rt_data[7:0]}};
      end
      default: ;
    endcase
  end

  logic        mfx_sel;
  logic [31:0] mfx_val;

`ifdef EX_MULDIV_EN
  logic [5:0] funct;
  logic       is_special;
  logic       inst_mult, inst_multu, inst_div, inst_divu;
  logic       inst_mfhi, inst_mflo, inst_mthi, inst_mtlo;
  assign funct      = inst[5:0];
  assign is_special = opcode == 6'b0;
  assign inst_mult  = is_special && funct == FUNCT_MULT;
  assign inst_multu = is_special && funct == FUNCT_MULTU;
  assign inst_div   = is_special && funct == FUNCT_DIV;
  assign inst_divu  = is_special && funct == FUNCT_DIVU;
  assign inst_mfhi  = is_special && funct == FUNCT_MFHI;
  assign inst_mflo  = is_special && funct == FUNCT_MFLO;
  assign inst_mthi  = is_special && funct == FUNCT_MTHI;
  assign inst_mtlo  = is_special && funct == FUNCT_MTLO;

  logic [63:0] prod_s, prod_u;
  assign prod_s = $unsigned($signed({{32{rs_data[31]}}, rs_data})
                          * $signed({{32{rt_data[31]}}, rt_data}));
  assign prod_u = {32'b0, rs_data} * {32'b0, rt_data};

  logic        div_busy, div_done;
  logic [31:0] div_quo, div_rem;

  div_iter u_div_iter (
    .clk       (clk),
    .rst       (rst),
    .start     (inst_div | inst_divu),
    .is_signed (inst_div),
    .advance   (stall[2] == NoStop),
    .dividend  (rs_data),
    .divisor   (rt_data),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  logic [31:0] hi, lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (div_done) begin
      hi <= div_rem;
      lo <= div_quo;
    end else if (inst_mult) begin
      {hi, lo} <= prod_s;
    end else if (inst_multu) begin
      {hi, lo} <= prod_u;
    end else begin
      if (inst_mthi) hi <= rs_data;
      if (inst_mtlo) lo <= rs_data;
    end
  end

  assign stallreq_for_ex = div_busy;
  assign mfx_sel         = inst_mfhi | inst_mflo;
  assign mfx_val         = inst_mfhi ? hi : lo;
`else
  assign stallreq_for_ex = 1'b0;
  assign mfx_sel         = 1'b0;
  assign mfx_val         = '0;
`endif

  logic unused_bits;
  assign unused_bits = ^{inst[25:16], stall[5:4], stall[1:0]};

  logic [31:0] ex_result;
  assign ex_result = mfx_sel ? mfx_val : alu_res;

  assign ex_to_mem_bus   = {pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result};
  assign ex_to_rf_bus    = {rf_we, rf_waddr, ex_result};
  assign ex_is_load      = sel_rf_res;
  assign data_sram_en    = ram_en;
  assign data_sram_wen   = (ram_wen != '0) ? lanes : '0;
  assign data_sram_addr  = addr;
  assign data_sram_wdata = wdata;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage -- directed self-checking bench for ex_stage.
//   Divider/HI-LO vectors run when EX_MULDIV_EN is defined; otherwise the
//   bench checks that those instructions are inert.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   stall, stall_tb;
  logic [158:0] id_to_ex_bus;
  logic [75:0]  ex_to_mem_bus;
  logic [37:0]  ex_to_rf_bus;
  logic         ex_is_load, stallreq_for_ex, data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr, data_sram_wdata;

  ex_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .id_to_ex_bus    (id_to_ex_bus),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .ex_to_rf_bus    (ex_to_rf_bus),
    .ex_is_load      (ex_is_load),
    .stallreq_for_ex (stallreq_for_ex),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
  );

  always #5 clk = ~clk;

  // CTRL behaviour: a divider stall freezes IF/ID/EX/MEM.
  always_comb stall = stall_tb | (stallreq_for_ex ? 6'b001111 : 6'b000000);

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  localparam logic [11:0] A_ADD = 12'h800, A_SUB = 12'h400, A_SLT = 12'h200, A_SLTU = 12'h100;
  localparam logic [11:0] A_AND = 12'h080, A_NOR = 12'h040, A_OR  = 12'h020, A_XOR  = 12'h010;
  localparam logic [11:0] A_SLL = 12'h008, A_SRL = 12'h004, A_SRA = 12'h002, A_LUI  = 12'h001;
  localparam logic [2:0]  S1_RS = 3'b001, S1_PC = 3'b010, S1_SA = 3'b100;
  localparam logic [3:0]  S2_RT = 4'b0001, S2_SI = 4'b0010, S2_8 = 4'b0100, S2_ZI = 4'b1000;
  localparam logic [31:0] PC0 = 32'hBFC0_0010;

  function automatic logic [158:0] mk(input logic [31:0] pc, input logic [31:0] inst,
      input logic [11:0] op, input logic [2:0] s1, input logic [3:0] s2,
      input logic ren, input logic [3:0] rwen, input logic we, input logic [4:0] wa,
      input logic ld, input logic [31:0] rs, input logic [31:0] rt);
    return {pc, inst, op, s1, s2, ren, rwen, we, wa, ld, rs, rt};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] imm);
    return {op, 5'd1, 5'd2, imm};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] sa, input logic [5:0] funct);
    return {6'h00, 5'd1, 5'd2, 5'd3, sa, funct};
  endfunction

  // Simple ALU op writing r3 with the given operands.
  function automatic logic [158:0] alu(input logic [11:0] op, input logic [2:0] s1,
      input logic [3:0] s2, input logic [31:0] inst, input logic [31:0] rs, input logic [31:0] rt);
    return mk(PC0, inst, op, s1, s2, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0, rs, rt);
  endfunction

  function automatic logic [158:0] special(input logic [5:0] funct, input logic we,
      input logic [31:0] rs, input logic [31:0] rt);
    return mk(PC0, rtype(5'd0, funct), 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0, we, 5'd3, 1'b0, rs, rt);
  endfunction

  task automatic issue(input logic [158:0] b);
    @(negedge clk);
    id_to_ex_bus = b;
    @(posedge clk);
    #1;
  endtask

  task automatic run_div(input logic [158:0] b, input logic [158:0] follow, output int unsigned cycles);
    issue(b);
    id_to_ex_bus = follow;
    cycles = 0;
    while (stallreq_for_ex && cycles < 100) begin
      cycles++;
      @(posedge clk);
      #1;
    end
    // follow-up instruction enters EX on this edge, HI/LO written on it too
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1);
  end

  initial begin
    int unsigned cyc;
    rst = 1'b1;
    stall_tb = '0;
    id_to_ex_bus = mk(PC0, itype(6'h09, 16'h0001), A_ADD, S1_RS, S2_SI, 1'b1, 4'hF, 1'b1, 5'd2, 1'b1,
                      32'h1234_5678, 32'h9ABC_DEF0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_bus", ex_to_mem_bus, '0);
    check("rst_rf_bus", ex_to_rf_bus, '0);
    check("rst_sram", {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}, '0);
    check("rst_flags", {stallreq_for_ex, ex_is_load}, '0);
    @(negedge clk);
    rst = 1'b0;

    // addiu overflow wraps
    issue(mk(PC0, itype(6'h09, 16'h0001), A_ADD, S1_RS, S2_SI, 1'b0, 4'h0, 1'b1, 5'd2, 1'b0,
             32'h7FFF_FFFF, 32'h0));
    check("addiu_rf", ex_to_rf_bus, {1'b1, 5'd2, 32'h8000_0000});
    check("addiu_mem", ex_to_mem_bus, {PC0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd2, 32'h8000_0000});
    check("addiu_stallreq", stallreq_for_ex, 1'b0);

    // hold: ID/EX and EX/MEM both stopped
    @(negedge clk);
    stall_tb = 6'b001111;
    id_to_ex_bus = mk(PC0, itype(OP_SB, 16'h0003), A_ADD, S1_RS, S2_SI, 1'b1, 4'hF, 1'b0, 5'd0, 1'b0,
                      32'h1000, 32'hAB);
    @(posedge clk);
    #1;
    check("hold_rf", ex_to_rf_bus, {1'b1, 5'd2, 32'h8000_0000});

    // bubble: ID/EX stopped, EX/MEM running
    @(negedge clk);
    stall_tb = 6'b000111;
    @(posedge clk);
    #1;
    check("bubble_mem", ex_to_mem_bus, '0);
    check("bubble_sram", {data_sram_en, data_sram_wen}, '0);
    check("bubble_rf", ex_to_rf_bus, '0);
    @(negedge clk);
    stall_tb = '0;

    // sb at byte 3
    issue(mk(PC0, itype(OP_SB, 16'h0003), A_ADD, S1_RS, S2_SI, 1'b1, 4'hF, 1'b0, 5'd0, 1'b0,
             32'h1000, 32'hAB));
    check("sb_sram", {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata},
          {1'b1, 4'b1000, 32'h0000_1003, 32'hABAB_ABAB});

    // sh at upper half
    issue(mk(PC0, itype(OP_SH, 16'h0002), A_ADD, S1_RS, S2_SI, 1'b1, 4'hF, 1'b0, 5'd0, 1'b0,
             32'h1000, 32'h1234_5678));
    check("sh_sram", {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata},
          {1'b1, 4'b1100, 32'h0000_1002, 32'h5678_5678});

    // sw with negative offset
    issue(mk(PC0, itype(OP_SW, 16'hFFFC), A_ADD, S1_RS, S2_SI, 1'b1, 4'hF, 1'b0, 5'd0, 1'b0,
             32'h2000, 32'hCAFE_F00D));
    check("sw_sram", {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata},
          {1'b1, 4'b1111, 32'h0000_1FFC, 32'hCAFE_F00D});

    // lw: enable without write lanes, load flag set
    issue(mk(PC0, itype(6'h23, 16'h0008), A_ADD, S1_RS, S2_SI, 1'b1, 4'h0, 1'b1, 5'd2, 1'b1,
             32'h3000, 32'h5555_5555));
    check("lw_sram", {data_sram_en, data_sram_wen, data_sram_addr}, {1'b1, 4'b0000, 32'h0000_3008});
    check("lw_is_load", ex_is_load, 1'b1);

    issue(alu(A_SUB, S1_RS, S2_RT, rtype(5'd0, 6'h23), 32'd3, 32'd5));
    check("subu", ex_to_rf_bus, {1'b1, 5'd3, 32'hFFFF_FFFE});
    issue(alu(A_SLT, S1_RS, S2_RT, rtype(5'd0, 6'h2a), 32'hFFFF_FFFF, 32'd1));
    check("slt", ex_to_rf_bus[31:0], 32'd1);
    issue(alu(A_SLTU, S1_RS, S2_RT, rtype(5'd0, 6'h2b), 32'hFFFF_FFFF, 32'd1));
    check("sltu", ex_to_rf_bus[31:0], 32'd0);
    issue(alu(A_SRA, S1_SA, S2_RT, rtype(5'd4, 6'h03), 32'h0, 32'h8000_0000));
    check("sra", ex_to_rf_bus[31:0], 32'hF800_0000);
    issue(alu(A_SRL, S1_SA, S2_RT, rtype(5'd4, 6'h02), 32'h0, 32'h8000_0000));
    check("srl", ex_to_rf_bus[31:0], 32'h0800_0000);
    issue(alu(A_SLL, S1_SA, S2_RT, rtype(5'd4, 6'h00), 32'h0, 32'h0000_000F));
    check("sll", ex_to_rf_bus[31:0], 32'h0000_00F0);
    issue(alu(A_LUI, 3'b000, S2_ZI, itype(6'h0f, 16'h1234), 32'h0, 32'h0));
    check("lui", ex_to_rf_bus[31:0], 32'h1234_0000);
    issue(alu(A_ADD, S1_PC, S2_8, 32'h0C00_0000, 32'h0, 32'h0));
    check("jal_link", ex_to_rf_bus[31:0], PC0 + 32'd8);
    issue(alu(A_OR, S1_RS, S2_ZI, itype(6'h0d, 16'h8001), 32'h00FF_0000, 32'h0));
    check("ori", ex_to_rf_bus[31:0], 32'h00FF_8001);
    issue(alu(A_AND, S1_RS, S2_ZI, itype(6'h0c, 16'h8001), 32'hFFFF_FFFF, 32'h0));
    check("andi", ex_to_rf_bus[31:0], 32'h0000_8001);
    issue(alu(A_XOR, S1_RS, S2_RT, rtype(5'd0, 6'h26), 32'hF0F0_F0F0, 32'hFF00_FF00));
    check("xor", ex_to_rf_bus[31:0], 32'h0FF0_0FF0);
    issue(alu(A_NOR, S1_RS, S2_RT, rtype(5'd0, 6'h27), 32'h0, 32'h0));
    check("nor", ex_to_rf_bus[31:0], 32'hFFFF_FFFF);
    issue(alu(A_ADD, S1_RS, S2_SI, itype(6'h09, 16'hFFFF), 32'h10, 32'h0));
    check("addiu_neg", ex_to_rf_bus[31:0], 32'h0000_000F);

`ifdef EX_MULDIV_EN
    // reset in the middle of a divide; HI/LO still hold their reset value
    issue(special(FUNCT_DIV, 1'b0, 32'hFFFF_FFF9, 32'd2));
    id_to_ex_bus = '0;
    repeat (10) @(posedge clk);
    #1;
    check("div_busy_c10", stallreq_for_ex, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("divrst_stallreq", stallreq_for_ex, 1'b0);
    check("divrst_mem_bus", ex_to_mem_bus, '0);
    check("divrst_sram", {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}, '0);
    @(negedge clk);
    rst = 1'b0;
    issue(special(FUNCT_MFHI, 1'b1, 32'h0, 32'h0));
    check("divrst_hi", ex_to_rf_bus, {1'b1, 5'd3, 32'h0});
    issue(special(FUNCT_MFLO, 1'b1, 32'h0, 32'h0));
    check("divrst_lo", ex_to_rf_bus, {1'b1, 5'd3, 32'h0});

    // signed divide -7 / 2, mflo right behind it
    run_div(special(FUNCT_DIV, 1'b0, 32'hFFFF_FFF9, 32'd2), special(FUNCT_MFLO, 1'b1, 32'h0, 32'h0), cyc);
    check("div_stall_cycles", cyc, 32'd33);
    check("div_lo", ex_to_rf_bus, {1'b1, 5'd3, 32'hFFFF_FFFD});
    check("div_stall_after", stallreq_for_ex, 1'b0);
    issue(special(FUNCT_MFHI, 1'b1, 32'h0, 32'h0));
    check("div_hi", ex_to_rf_bus[31:0], 32'hFFFF_FFFF);

    // unsigned divide by zero
    run_div(special(FUNCT_DIVU, 1'b0, 32'd5, 32'd0), special(FUNCT_MFHI, 1'b1, 32'h0, 32'h0), cyc);
    check("divu0_stall_cycles", cyc, 32'd33);
    check("divu0_hi", ex_to_rf_bus[31:0], 32'd5);
    issue(special(FUNCT_MFLO, 1'b1, 32'h0, 32'h0));
    check("divu0_lo", ex_to_rf_bus[31:0], 32'hFFFF_FFFF);

    // signed multiply -2 * 3
    issue(special(FUNCT_MULT, 1'b0, 32'hFFFF_FFFE, 32'd3));
    check("mult_stallreq", stallreq_for_ex, 1'b0);
    issue(special(FUNCT_MFLO, 1'b1, 32'h0, 32'h0));
    check("mult_lo", ex_to_rf_bus[31:0], 32'hFFFF_FFFA);
    issue(special(FUNCT_MFHI, 1'b1, 32'h0, 32'h0));
    check("mult_hi", ex_to_rf_bus[31:0], 32'hFFFF_FFFF);

    // unsigned multiply 0xFFFFFFFF * 2
    issue(special(FUNCT_MULTU, 1'b0, 32'hFFFF_FFFF, 32'd2));
    issue(special(FUNCT_MFHI, 1'b1, 32'h0, 32'h0));
    check("multu_hi", ex_to_rf_bus[31:0], 32'h0000_0001);
    issue(special(FUNCT_MFLO, 1'b1, 32'h0, 32'h0));
    check("multu_lo", ex_to_rf_bus[31:0], 32'hFFFF_FFFE);

    // mthi / mtlo
    issue(special(FUNCT_MTHI, 1'b0, 32'hDEAD_BEEF, 32'h0));
    issue(special(FUNCT_MTLO, 1'b0, 32'h0123_4567, 32'h0));
    issue(special(FUNCT_MFHI, 1'b1, 32'h0, 32'h0));
    check("mthi", ex_to_rf_bus[31:0], 32'hDEAD_BEEF);
    issue(special(FUNCT_MFLO, 1'b1, 32'h0, 32'h0));
    check("mtlo", ex_to_rf_bus[31:0], 32'h0123_4567);
`else
    // without the HI/LO unit a divide never stalls and mfhi reads 0
    issue(special(FUNCT_DIV, 1'b0, 32'hFFFF_FFF9, 32'd2));
    check("nomd_div_stallreq", stallreq_for_ex, 1'b0);
    @(posedge clk);
    #1;
    check("nomd_div_stallreq2", stallreq_for_ex, 1'b0);
    issue(special(FUNCT_MTHI, 1'b0, 32'hDEAD_BEEF, 32'h0));
    issue(special(FUNCT_MFHI, 1'b1, 32'h0, 32'h0));
    check("nomd_mfhi", ex_to_rf_bus, {1'b1, 5'd3, 32'h0});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage MIPS pipeline, between ID and MEM. Registers the ID→EX bus and selects ALU operands. Computes the ALU result and drives the data-SRAM request for loads and stores. Owns the HI/LO registers and a 32-iteration divider, and raises a stall request while a divide is in flight. Forwards its result to ID over the EX→RF bus.

## Interface
Parameters:
- none; all widths come from shared defines (`ID_TO_EX_WD`=159, `EX_TO_MEM_WD`=76, `EX_TO_RF_WD`=38, `StallBus`=6).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stall  in  StallBus  pipeline stall vector from CTRL; bit 2 = ID/EX register, bit 3 = EX/MEM register
- id_to_ex_bus  in  159  fields, MSB first:
  - pc[158:127], inst[126:95], alu_op[94:83]
  - sel_src1[82:80], sel_src2[79:76]
  - ram_en[75], ram_wen[74:71], rf_we[70], rf_waddr[69:65], sel_rf_res[64]
  - rs_data[63:32], rt_data[31:0]
- ex_to_mem_bus  out  76  {pc, ram_en, ram_wen[3:0], sel_rf_res, rf_we, rf_waddr, ex_result}
- ex_to_rf_bus  out  38  {rf_we, rf_waddr, ex_result}; forwarding path to ID
- ex_is_load  out  1  equals sel_rf_res; CTRL uses it to detect load-use hazards
- stallreq_for_ex  out  1  divide in progress
- data_sram_en  out  1  SRAM request
- data_sram_wen  out  4  byte write enables
- data_sram_addr  out  32  rs_data + sign_ext(inst[15:0])
- data_sram_wdata  out  32  store data, lane-replicated

## Operation
Input register update, evaluated in priority order:
- rst → cleared to 0.
- stall[2]=Stop and stall[3]=NoStop → cleared to 0 (bubble).
- stall[2]=NoStop → load id_to_ex_bus.
- otherwise → hold.

Operand selection:
- src1: sel_src1[0] → rs_data; [1] → pc; [2] → zero_ext(inst[10:6]).
- src2: sel_src2[0] → rt_data; [1] → sign_ext(imm); [2] → 32'd8; [3] → zero_ext(imm).
- Selects are one-hot; an all-zero select gives 0.

ALU:
- alu_op is one-hot, MSB first: add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui.
- add/sub wrap modulo 2^32; overflow is ignored.
- Shifts use src1[4:0] as the shift amount applied to src2.
- lui produces {src2[15:0], 16'b0}.

Stores:
- Opcode selects lanes, with a = addr[1:0]:
  - sw → 4'b1111
  - sh → 4'b0011 << (2·a[1])
  - sb → 4'b0001 << a
- wdata: sw → rt; sh → {2{rt[15:0]}}; sb → {4{rt[7:0]}}.
- data_sram_en = ram_en; wen = 0 for loads.

HI/LO (present only with the macro):
- EX decodes the op=0 funct field itself: mult, multu, div, divu, mfhi, mflo, mthi, mtlo.
- mult/multu: full 64-bit product computed in one cycle; {HI,LO} written at the end of every cycle the instruction is in EX. Repeated writes are idempotent.
- mthi/mtlo write rs_data.
- mfhi/mflo set ex_result to the current HI/LO value.

Divider FSM (sub-module `div_iter`):
- IDLE: a div/divu is in EX → go to BUSY, latch |operands| and the sign info, count=0; stallreq=1.
- BUSY: one restoring step per cycle; stallreq=1; leave to DONE after the step with count=31.
- DONE: stallreq=0; HI←remainder and LO←quotient each cycle; go to IDLE on the edge where stall[2]=NoStop, which also loads the next instruction.
- Sign fix-up: quotient is negated when the operand signs differ; remainder takes the dividend's sign.
- Divide by zero: quotient = 0xFFFFFFFF and remainder = dividend, both computed on the unsigned magnitudes before sign fix-up.
- rst in any state → IDLE, counter 0, stallreq 0; the partial result is discarded.

## Timing
- Reset state: every output is 0, including stallreq_for_ex. HI and LO are 0.
- ALU and memory operations: 1 cycle in EX. ex_to_rf_bus is valid in the same cycle for ID forwarding.
- div/divu: 34 cycles in EX.
  - stallreq is high in cycles 0–32, where cycle 0 is the IDLE→BUSY decision cycle.
  - The result is on HI/LO after the edge that ends cycle 33.
- An mfhi/mflo immediately following a div reads the final value, because the divider stall holds it in ID.
- A bubble (all-zero bus) produces no SRAM access, no RF write and no HI/LO write.

## Configuration
- `EX_MULDIV_EN` defined: HI/LO registers, multiplier, `div_iter` and stallreq_for_ex are all implemented.
- `EX_MULDIV_EN` undefined:
  - mult/div/mf/mt decode is forced to 0; no HI/LO state exists.
  - stallreq_for_ex is tied to 0.
  - The stage acts as a pure 1-cycle ALU/AGU stage, and mfhi/mflo return 0.

## Structure
- Shared `lib/defines.vh` holds:
  - bus widths, `Stop`/`NoStop`;
  - funct codes for mult/multu/div/divu/mfhi/mflo/mthi/mtlo;
  - opcodes for sb/sh/sw.
- One sub-module, `div_iter`:
  - inputs: clk, rst, start, signed, dividend, divisor;
  - outputs: busy, done, quotient, remainder.
- The ALU stays inline as one-hot AND-OR muxing.

## Test plan
- addiu: rs=0x7FFFFFFF, imm=1 → ex_result 0x80000000, rf_we=1, stallreq stays 0.
- sb: rs=0x1000, imm=3, rt=0xAB → addr 0x1003, wen 4'b1000, wdata 0xABABABAB.
- div: rs=−7, rt=2 → stallreq high for exactly 33 cycles; then LO=0xFFFFFFFD (−3) and HI=0xFFFFFFFF (−1).
- divu: rs=5, rt=0 → LO=0xFFFFFFFF, HI=5.
- rst asserted at cycle 10 of a divide → next cycle stallreq=0 and all outputs 0; HI/LO unchanged from before the divide.
- stall[2]=Stop with stall[3]=NoStop → bubble: ex_to_mem_bus=0 and data_sram_en=0.
